y86_seq_stage_ctrl: RTL and testbench



---
 rtl/y86_pkg.sv | 39 +++
 rtl/y86_wait_timer.sv | 29 ++
 rtl/y86_seq_stage_ctrl.sv | 165 ++++++++++++++++
 tb/tb_y86_seq_stage_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 SEQ stage sequencer: status codes, icodes,
// stage encoding and the data-memory instruction classifier.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StPcupd,
        StHalted
    } stage_t;

    function automatic logic uses_dmem(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_MRMOVQ) || (icode == I_CALL) ||
               (icode == I_RET) || (icode == I_PUSHQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/y86_wait_timer.sv
// Counts consecutive not-ready cycles of a memory handshake; o_limit marks the last
// tolerated wait cycle and o_timeout is that cycle still not ready.
module y86_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_limit,
    output logic o_timeout
);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_limit   = (r_count == 8'(MEM_TIMEOUT - 1));
    assign o_timeout = o_limit & i_inc;

endmodule

// File: rtl/y86_seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ core: walks each instruction through
// the six stages, maps faults onto the architectural status and keeps debug counters.
module y86_seq_stage_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_imem_ready,
    input  logic             i_imem_error,
    input  logic             i_instr_valid,
    input  logic [3:0]       i_icode,
    input  logic             i_dmem_ready,
    input  logic             i_dmem_error,
    output logic             o_fetch_en,
    output logic             o_decode_en,
    output logic             o_execute_en,
    output logic             o_memory_en,
    output logic             o_dmem_req,
    output logic             o_writeback_en,
    output logic             o_pc_update_en,
    output logic             o_busy,
    output logic             o_halted,
    output logic [2:0]       o_stat,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_retired_count
);

    stage_t     r_state, w_state_d;
    logic [2:0] r_stat, w_stat_d;
    logic [3:0] r_icode, w_icode_d;
    logic [CNT_W-1:0] r_cycle_count, r_retired_count;
    logic r_fetch_en, r_decode_en, r_execute_en, r_memory_en, r_dmem_req;
    logic r_writeback_en, r_pc_update_en, r_busy, r_halted;
    logic w_wait_inc, w_wait_clear, w_limit, w_timeout;

    // Only a memory-type MEMORY stage waits on dmem_ready.
    assign w_wait_inc = ((r_state == StFetch) && !i_imem_ready) ||
                        ((r_state == StMemory) && uses_dmem(r_icode) && !i_dmem_ready);
    assign w_wait_clear = (w_state_d != r_state);

    y86_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_wait_clear),
        .i_inc    (w_wait_inc),
        .o_limit  (w_limit),
        .o_timeout(w_timeout)
    );

    always_comb begin
        w_state_d = r_state;
        w_stat_d  = r_stat;
        w_icode_d = r_icode;
        unique case (r_state)
            StIdle: begin
                if (i_start) w_state_d = StFetch;
            end
            StHalted: begin
                if (i_start) begin
                    w_state_d = StFetch;
                    w_stat_d  = STAT_AOK;
                end
            end
            StFetch: begin
                if (i_imem_ready) begin
                    if (i_imem_error) begin
                        w_state_d = StHalted;
                        w_stat_d  = STAT_ADR;
                    end else begin
                        w_state_d = StDecode;
                    end
                end else if (w_timeout) begin
                    w_state_d = StHalted;
                    w_stat_d  = STAT_ADR;
                end
            end
            StDecode: begin
                w_icode_d = i_icode;
                if (!i_instr_valid) begin
                    w_state_d = StHalted;
                    w_stat_d  = STAT_INS;
                end else if (i_icode == I_HALT) begin
                    w_state_d = StHalted;
                    w_stat_d  = STAT_HLT;
                end else begin
                    w_state_d = StExecute;
                end
            end
            StExecute: w_state_d = StMemory;
            StMemory: begin
                if (!uses_dmem(r_icode)) begin
                    w_state_d = StWriteback;
                end else if (i_dmem_ready) begin
                    if (i_dmem_error) begin
                        w_state_d = StHalted;
                        w_stat_d  = STAT_ADR;
                    end else begin
                        w_state_d = StWriteback;
                    end
                end else if (w_limit) begin
                    w_state_d = StHalted;
                    w_stat_d  = STAT_ADR;
                end
            end
            StWriteback: w_state_d = StPcupd;
            StPcupd:     w_state_d = StFetch;
            default:     w_state_d = StIdle;
        endcase
    end

    // Stage outputs are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= StIdle;
            r_stat          <= STAT_AOK;
            r_icode         <= I_HALT;
            r_cycle_count   <= '0;
            r_retired_count <= '0;
            r_fetch_en      <= 1'b0;
            r_decode_en     <= 1'b0;
            r_execute_en    <= 1'b0;
            r_memory_en     <= 1'b0;
            r_dmem_req      <= 1'b0;
            r_writeback_en  <= 1'b0;
            r_pc_update_en  <= 1'b0;
            r_busy          <= 1'b0;
            r_halted        <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_stat         <= w_stat_d;
            r_icode        <= w_icode_d;
            r_fetch_en     <= (w_state_d == StFetch);
            r_decode_en    <= (w_state_d == StDecode);
            r_execute_en   <= (w_state_d == StExecute);
            r_memory_en    <= (w_state_d == StMemory);
            r_dmem_req     <= (w_state_d == StMemory) && uses_dmem(w_icode_d);
            r_writeback_en <= (w_state_d == StWriteback);
            r_pc_update_en <= (w_state_d == StPcupd);
            r_busy         <= (w_state_d != StIdle) && (w_state_d != StHalted);
            r_halted       <= (w_state_d == StHalted);
            if (r_busy) r_cycle_count <= r_cycle_count + 1'b1;
            if (r_state == StPcupd) r_retired_count <= r_retired_count + 1'b1;
        end
    end

    assign o_fetch_en      = r_fetch_en;
    assign o_decode_en     = r_decode_en;
    assign o_execute_en    = r_execute_en;
    assign o_memory_en     = r_memory_en;
    assign o_dmem_req      = r_dmem_req;
    assign o_writeback_en  = r_writeback_en;
    assign o_pc_update_en  = r_pc_update_en;
    assign o_busy          = r_busy;
    assign o_halted        = r_halted;
    assign o_stat          = r_stat;
    assign o_cycle_count   = r_cycle_count;
    assign o_retired_count = r_retired_count;

endmodule

// File: tb/tb_y86_seq_stage_ctrl.sv
// Bench for y86_seq_stage_ctrl: instructions are described as transactions (wait
// lengths, faults, icode) and expanded into the expected per-cycle stage timeline.
module tb_y86_seq_stage_ctrl;

    localparam int unsigned MT = 15;

    // {fetch, decode, execute, memory, dmem_req, writeback, pc_update, busy, halted}
    localparam logic [8:0] V_IDLE  = 9'b0000000_00;
    localparam logic [8:0] V_HALT  = 9'b0000000_01;
    localparam logic [8:0] V_FETCH = 9'b1000000_10;
    localparam logic [8:0] V_DEC   = 9'b0100000_10;
    localparam logic [8:0] V_EXE   = 9'b0010000_10;
    localparam logic [8:0] V_MEM   = 9'b0001000_10;
    localparam logic [8:0] V_MEMRQ = 9'b0001100_10;
    localparam logic [8:0] V_WB    = 9'b0000010_10;
    localparam logic [8:0] V_PC    = 9'b0000001_10;

    localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0, i_imem_ready = 1'b0, i_imem_error = 1'b0;
    logic        i_instr_valid = 1'b0, i_dmem_ready = 1'b0, i_dmem_error = 1'b0;
    logic [3:0]  i_icode = 4'h0;
    logic        o_fetch_en, o_decode_en, o_execute_en, o_memory_en, o_dmem_req;
    logic        o_writeback_en, o_pc_update_en, o_busy, o_halted;
    logic [2:0]  o_stat;
    logic [31:0] o_cycle_count, o_retired_count;
    logic [8:0]  act_vec;

    int n_checks = 0;
    int n_errors = 0;
    int m_cycles = 0;
    int m_retired = 0;
    logic [2:0] m_stat = AOK;
    bit stopped;

    always #5 clk = ~clk;

    y86_seq_stage_ctrl #(
        .CNT_W      (32),
        .MEM_TIMEOUT(MT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_imem_ready   (i_imem_ready),
        .i_imem_error   (i_imem_error),
        .i_instr_valid  (i_instr_valid),
        .i_icode        (i_icode),
        .i_dmem_ready   (i_dmem_ready),
        .i_dmem_error   (i_dmem_error),
        .o_fetch_en     (o_fetch_en),
        .o_decode_en    (o_decode_en),
        .o_execute_en   (o_execute_en),
        .o_memory_en    (o_memory_en),
        .o_dmem_req     (o_dmem_req),
        .o_writeback_en (o_writeback_en),
        .o_pc_update_en (o_pc_update_en),
        .o_busy         (o_busy),
        .o_halted       (o_halted),
        .o_stat         (o_stat),
        .o_cycle_count  (o_cycle_count),
        .o_retired_count(o_retired_count)
    );

    assign act_vec = {o_fetch_en, o_decode_en, o_execute_en, o_memory_en, o_dmem_req,
                      o_writeback_en, o_pc_update_en, o_busy, o_halted};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Check the current cycle's outputs, account for it in the model, advance one clock.
    task automatic cyc(input logic [8:0] exp_vec);
        check("stage", 32'(act_vec), 32'(exp_vec));
        check("stat", 32'(o_stat), 32'(m_stat));
        check("cycles", o_cycle_count, 32'(m_cycles));
        check("retired", o_retired_count, 32'(m_retired));
        if (exp_vec[1]) m_cycles++;
        if (exp_vec[2]) m_retired++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_start = 1'b0;
        m_stat = AOK;
        m_cycles = 0;
        m_retired = 0;
    endtask

    task automatic start_from(input logic [8:0] v);
        i_start = 1'b1;
        cyc(v);
        i_start = 1'b0;
        m_stat = AOK;
    endtask

    // One instruction from FETCH entry: fw/mw are not-ready cycles before ready.
    task automatic run_instr(input int fw, input bit ferr, input bit valid,
                             input logic [3:0] ic, input int mw, input bit merr,
                             output bit stop);
        bit mem;
        stop = 1'b1;
        mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        for (int k = 0; k < 64; k++) begin
            i_start = 1'($urandom);
            i_imem_ready = (k >= fw);
            i_imem_error = (k >= fw) ? ferr : 1'($urandom);
            i_icode = 4'($urandom);
            i_instr_valid = 1'($urandom);
            cyc(V_FETCH);
            if (k >= fw) begin
                if (ferr) begin
                    m_stat = ADR;
                    return;
                end
                break;
            end
            if (k == MT - 1) begin
                m_stat = ADR;
                return;
            end
        end
        i_start = 1'($urandom);
        i_instr_valid = valid;
        i_icode = ic;
        cyc(V_DEC);
        if (!valid) begin
            m_stat = INS;
            return;
        end
        if (ic == 4'h0) begin
            m_stat = HLT;
            return;
        end
        i_start = 1'($urandom);
        i_instr_valid = 1'($urandom);
        cyc(V_EXE);
        if (!mem) begin
            i_dmem_ready = 1'($urandom);
            i_dmem_error = 1'($urandom);
            cyc(V_MEM);
        end else begin
            for (int k = 0; k < 64; k++) begin
                i_start = 1'($urandom);
                i_dmem_ready = (k >= mw);
                i_dmem_error = (k >= mw) ? merr : 1'($urandom);
                cyc(V_MEMRQ);
                if (k >= mw) begin
                    if (merr) begin
                        m_stat = ADR;
                        return;
                    end
                    break;
                end
                if (k == MT - 1) begin
                    m_stat = ADR;
                    return;
                end
            end
        end
        i_start = 1'($urandom);
        cyc(V_WB);
        i_start = 1'($urandom);
        cyc(V_PC);
        stop = 1'b0;
    endtask

    // After a stopping instruction: dwell in HALTED, then restart.
    task automatic recover();
        i_start = 1'b0;
        repeat ($urandom_range(1, 3)) cyc(V_HALT);
        start_from(V_HALT);
    endtask

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 0;
        if (r < 8) return $urandom_range(1, 4);
        return $urandom_range(MT - 2, MT + 2);
    endfunction

    initial begin
        do_reset();
        cyc(V_IDLE);
        start_from(V_IDLE);

        // zero-wait nop loop
        repeat (5) run_instr(0, 0, 1, 4'h1, 0, 0, stopped);
        check("nop_retired", o_retired_count, 32'd5);
        check("nop_cycles", o_cycle_count, 32'd30);

        // mrmovq with three data-memory wait cycles
        run_instr(0, 0, 1, 4'h5, 3, 0, stopped);
        check("mrmovq_retired", o_retired_count, 32'd6);
        check("mrmovq_cycles", o_cycle_count, 32'd39);

        // halt, then illegal instruction with icode 0 (INS must win)
        run_instr(0, 0, 1, 4'h0, 0, 0, stopped);
        check("halt_stop", 32'(stopped), 32'd1);
        recover();
        run_instr(0, 0, 0, 4'h0, 0, 0, stopped);
        check("ins_stat_model", 32'(m_stat), 32'(INS));
        recover();

        // fetch/memory timeouts and ready on the last tolerated cycle
        run_instr(20, 0, 1, 4'h1, 0, 0, stopped);
        recover();
        run_instr(MT - 1, 0, 1, 4'h1, 0, 0, stopped);
        check("fetch_limit_ok", 32'(stopped), 32'd0);
        run_instr(0, 0, 1, 4'h8, 20, 0, stopped);
        recover();
        run_instr(0, 0, 1, 4'h9, MT - 1, 0, stopped);
        check("mem_limit_ok", 32'(stopped), 32'd0);
        run_instr(0, 1, 1, 4'h1, 0, 0, stopped);
        recover();
        run_instr(0, 0, 1, 4'hA, 2, 1, stopped);
        recover();

        // reset in the middle of a memory-type MEMORY stage
        do_reset();
        cyc(V_IDLE);
        start_from(V_IDLE);
        i_imem_ready = 1'b1;
        i_imem_error = 1'b0;
        cyc(V_FETCH);
        i_instr_valid = 1'b1;
        i_icode = 4'h4;
        cyc(V_DEC);
        cyc(V_EXE);
        i_dmem_ready = 1'b0;
        cyc(V_MEMRQ);
        cyc(V_MEMRQ);
        do_reset();
        cyc(V_IDLE);

        // randomized instruction stream
        start_from(V_IDLE);
        repeat (150) begin
            run_instr(rand_wait(), ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) != 0),
                      4'($urandom), rand_wait(), ($urandom_range(0, 19) == 0), stopped);
            if (stopped) recover();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
